// File: rtl/vit_dec_depunct.sv
// Depuncturer: slots serial symbols into one trellis step per the frame's puncture mode; punctured slots become erasures.
// Latency: a step is presented one cycle after the symbol that fills its last kept slot (or carries ieop).
// Backpressure: none; at most one symbol in and one step out per enabled clock, iclkena low freezes everything.
module vit_dec_depunct #(
  parameter int pCODE_GEN_NUM = 2,
  parameter int pLLR_W        = 4,
  parameter int pTAG_W        = 4,
  parameter int pMODE_NUM     = 3,
  parameter int pPUNCT_PERIOD [pMODE_NUM] = '{1, 2, 3},
  parameter int pPUNCT_MASK   [pMODE_NUM] = '{'h3, 'h7, 'h27},
  parameter int pSTEP_CNT_W   = 16,
  localparam int cMODE_W      = (pMODE_NUM > 1) ? $clog2(pMODE_NUM) : 1
) (
  input  logic                              iclk,
  input  logic                              ireset,
  input  logic                              iclkena,
  input  logic                              isop,
  input  logic                              ival,
  input  logic                              ieop,
  input  logic [pTAG_W-1:0]                 itag,
  input  logic [cMODE_W-1:0]                imode,
  input  logic [pLLR_W-1:0]                 iLLR,
  output logic                              osop,
  output logic                              oval,
  output logic                              oeop,
  output logic [pTAG_W-1:0]                 otag,
  output logic [pCODE_GEN_NUM*pLLR_W-1:0]   oLLR,
  output logic [pCODE_GEN_NUM-1:0]          odat,
  output logic [pCODE_GEN_NUM-1:0]          oerase,
  output logic [pSTEP_CNT_W-1:0]            ostep_cnt,
  output logic                              ofrm_err
);

  localparam int cG      = pCODE_GEN_NUM;
  localparam int cG_W    = (cG > 1) ? $clog2(cG) : 1;
  localparam int cSLOT_W = cG * pLLR_W;

  // A pattern step with no kept position would stall the assembler forever.
  for (genvar m = 0; m < pMODE_NUM; m++) begin : g_chk_mode
    if (pPUNCT_PERIOD[m] < 1 || pPUNCT_PERIOD[m] > 8) begin : g_bad_period
      $error("puncture period out of range 1..8");
    end
    for (genvar s = 0; s < 8; s++) begin : g_chk_step
      if (s < pPUNCT_PERIOD[m] && ((pPUNCT_MASK[m] >> (s * cG)) & ((1 << cG) - 1)) == 0) begin : g_bad_step
        $error("puncture step keeps no position");
      end
    end
  end

  // Keep mask of one step of one pattern.
  function automatic logic [cG-1:0] keep_of(input logic [cMODE_W-1:0] m, input logic [2:0] s);
    logic [31:0] mk;
    mk = pPUNCT_MASK[m];
    return mk[int'(s)*cG +: cG];
  endfunction

  // Lowest kept position of a step.
  function automatic logic [cG_W-1:0] first_kept(input logic [cG-1:0] k);
    logic [cG_W-1:0] f;
    f = '0;
    for (int j = cG - 1; j >= 0; j--) begin
      if (k[j]) f = cG_W'(j);
    end
    return f;
  endfunction

  logic                     active_r;
  logic [cMODE_W-1:0]       mode_r;
  logic [pTAG_W-1:0]        tag_r;
  logic [2:0]               phase_r;
  logic [cG_W-1:0]          pos_r;
  logic [cSLOT_W-1:0]       slot_r;
  logic [cG-1:0]            wr_r;
  logic                     first_r;
  logic [pSTEP_CNT_W-1:0]   cnt_r;

  logic                     sym_acc, mode_ok, more, step_done, err;
  logic [cMODE_W-1:0]       cur_mode;
  logic [2:0]               cur_phase, nxt_phase;
  logic [cG-1:0]            cur_keep, new_wr, one_hot, dat_n;
  logic [cG_W-1:0]          cur_pos, nxt_pos, nxt_first;
  logic [cSLOT_W-1:0]       new_slot;
  logic [pSTEP_CNT_W-1:0]   cnt_n;

  // A symbol carrying isop restarts phase/position/slots under the newly sampled mode.
  always_comb begin
    sym_acc   = ival & (isop | active_r);
    mode_ok   = int'(imode) < pMODE_NUM;
    cur_mode  = isop ? (mode_ok ? imode : '0) : mode_r;
    cur_phase = isop ? 3'd0 : phase_r;
    cur_keep  = keep_of(cur_mode, cur_phase);
    cur_pos   = isop ? first_kept(cur_keep) : pos_r;
    new_slot  = isop ? '0 : slot_r;
    new_slot[int'(cur_pos)*pLLR_W +: pLLR_W] = iLLR;
    one_hot   = '0;
    one_hot[cur_pos] = 1'b1;
    new_wr    = (isop ? '0 : wr_r) | one_hot;
    more      = 1'b0;
    nxt_pos   = cur_pos;
    for (int j = cG - 1; j >= 0; j--) begin
      if (cur_keep[j] && j > int'(cur_pos)) begin
        more    = 1'b1;
        nxt_pos = cG_W'(j);
      end
    end
    step_done = sym_acc & (~more | ieop);
    err       = (ival & isop & (active_r | ~mode_ok)) | (sym_acc & ieop & more);
    nxt_phase = (int'(cur_phase) + 1 >= pPUNCT_PERIOD[cur_mode]) ? 3'd0 : cur_phase + 3'd1;
    nxt_first = first_kept(keep_of(cur_mode, nxt_phase));
    cnt_n     = isop ? '0 : cnt_r;
    cnt_n     = (cnt_n == '1) ? cnt_n : cnt_n + 1'b1;
    for (int g = 0; g < cG; g++) begin
      dat_n[g] = new_slot[g*pLLR_W + pLLR_W - 1];
    end
  end

  // Frame/step state and registered step outputs; strobes clear on every enabled edge.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      active_r  <= 1'b0;
      mode_r    <= '0;
      tag_r     <= '0;
      phase_r   <= '0;
      pos_r     <= '0;
      slot_r    <= '0;
      wr_r      <= '0;
      first_r   <= 1'b0;
      cnt_r     <= '0;
      osop      <= 1'b0;
      oval      <= 1'b0;
      oeop      <= 1'b0;
      otag      <= '0;
      oLLR      <= '0;
      odat      <= '0;
      oerase    <= '0;
      ostep_cnt <= '0;
      ofrm_err  <= 1'b0;
    end else if (iclkena) begin
      oval     <= 1'b0;
      osop     <= 1'b0;
      oeop     <= 1'b0;
      ofrm_err <= err;
      if (sym_acc) begin
        mode_r <= cur_mode;
        if (isop) tag_r <= itag;
        if (step_done) begin
          oval      <= 1'b1;
          osop      <= isop | first_r;
          oeop      <= ieop;
          otag      <= isop ? itag : tag_r;
          oLLR      <= new_slot;
          odat      <= dat_n;
          oerase    <= ~new_wr;
          ostep_cnt <= cnt_n;
          cnt_r     <= cnt_n;
          first_r   <= 1'b0;
          slot_r    <= '0;
          wr_r      <= '0;
          phase_r   <= nxt_phase;
          pos_r     <= nxt_first;
          active_r  <= ~ieop;
        end else begin
          slot_r    <= new_slot;
          wr_r      <= new_wr;
          pos_r     <= nxt_pos;
          phase_r   <= cur_phase;
          first_r   <= isop | first_r;
          if (isop) cnt_r <= '0;
          active_r  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vit_dec_depunct.sv
// Bench for vit_dec_depunct: directed per-cycle vector table, reset sequences,
// then random frames on a 4-bit build (always enabled) and a hard-decision build (random clock enable).
module tb_vit_dec_depunct;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic        ireset, en_a, en_b, isop, ival, ieop;
  logic [3:0]  itag, illr;
  logic [1:0]  imode;

  logic        osop_a, oval_a, oeop_a, oerr_a;
  logic [3:0]  otag_a;
  logic [7:0]  ollr_a;
  logic [1:0]  odat_a, oerase_a;
  logic [15:0] ocnt_a;

  logic        osop_b, oval_b, oeop_b, oerr_b;
  logic [3:0]  otag_b;
  logic [1:0]  ollr_b, odat_b, oerase_b;
  logic [15:0] ocnt_b;

  vit_dec_depunct #(.pLLR_W(4)) u_a (
    .iclk(iclk), .ireset(ireset), .iclkena(en_a), .isop(isop), .ival(ival), .ieop(ieop),
    .itag(itag), .imode(imode), .iLLR(illr),
    .osop(osop_a), .oval(oval_a), .oeop(oeop_a), .otag(otag_a), .oLLR(ollr_a),
    .odat(odat_a), .oerase(oerase_a), .ostep_cnt(ocnt_a), .ofrm_err(oerr_a)
  );

  vit_dec_depunct #(.pLLR_W(1)) u_b (
    .iclk(iclk), .ireset(ireset), .iclkena(en_b), .isop(isop), .ival(ival), .ieop(ieop),
    .itag(itag), .imode(imode), .iLLR(illr[3]),
    .osop(osop_b), .oval(oval_b), .oeop(oeop_b), .otag(otag_b), .oLLR(ollr_b),
    .odat(odat_b), .oerase(oerase_b), .ostep_cnt(ocnt_b), .ofrm_err(oerr_b)
  );

  typedef struct {
    logic [3:0]  l0, l1;
    logic [1:0]  er;
    logic        sop, eop, err;
    logic [15:0] cnt;
    logic [3:0]  tag;
  } step_t;

  typedef struct {
    logic       val, sop, eop;
    logic [1:0] md;
    logic [3:0] tg, lv;
    logic       xv, xs, xe, xf;
    logic [3:0] x0, x1;
    logic [1:0] xer;
    int         xc;
  } vec_t;

  int    nvec = 0;
  int    nerr = 0;
  bit    chk_a = 0, chk_b = 0;
  step_t expa[$];
  step_t expb[$];
  vec_t  tbl[$];

  int per[3] = '{1, 2, 3};
  int msk[3] = '{'h3, 'h7, 'h27};

  task automatic v(input logic val, sop, eop, input logic [1:0] md, input logic [3:0] tg, lv,
                   input logic xv, xs, xe, xf, input logic [3:0] x0, x1, input logic [1:0] xer, input int xc);
    vec_t r;
    r.val = val; r.sop = sop; r.eop = eop; r.md = md; r.tg = tg; r.lv = lv;
    r.xv = xv; r.xs = xs; r.xe = xe; r.xf = xf; r.x0 = x0; r.x1 = x1; r.xer = xer; r.xc = xc;
    tbl.push_back(r);
  endtask

  task automatic vn(input logic val, sop, eop, input logic [1:0] md, input logic [3:0] tg, lv, input logic xf);
    v(val, sop, eop, md, tg, lv, 1'b0, 1'b0, 1'b0, xf, 4'h0, 4'h0, 2'b00, 0);
  endtask

  // Expected steps of one frame, derived directly from the pattern table.
  task automatic model(input int m, input int n, input logic [3:0] tg, input logic [3:0] sy [16], input bit to_b);
    int idx, s, cnt;
    step_t st;
    idx = 0; s = 0; cnt = 0;
    while (idx < n) begin
      st.l0 = 4'h0; st.l1 = 4'h0; st.er = 2'b11; st.err = 1'b0;
      st.sop = (cnt == 0); st.eop = 1'b0; st.tag = tg;
      for (int g = 0; g < 2; g++) begin
        if (((msk[m] >> (s * 2 + g)) & 1) == 1) begin
          if (idx < n) begin
            if (g == 0) st.l0 = sy[idx]; else st.l1 = sy[idx];
            st.er[g] = 1'b0;
            idx++;
            if (idx == n) st.eop = 1'b1;
          end else begin
            st.err = 1'b1;
          end
        end
      end
      cnt++;
      st.cnt = 16'(cnt);
      if (to_b) expb.push_back(st); else expa.push_back(st);
      s = (s + 1) % per[m];
    end
  endtask

  task automatic cmp_step(input string nm, input bit b, input step_t e);
    logic [7:0]  gl, wl;
    logic [1:0]  gd, ger, wd;
    logic        gv, gs, ge, gf;
    logic [15:0] gc;
    logic [3:0]  gt;
    wd = {e.l1[3], e.l0[3]};
    if (b) begin
      gv = oval_b; gs = osop_b; ge = oeop_b; gf = oerr_b; gl = {6'b0, ollr_b}; gd = odat_b;
      ger = oerase_b; gc = ocnt_b; gt = otag_b; wl = {6'b0, wd};
    end else begin
      gv = oval_a; gs = osop_a; ge = oeop_a; gf = oerr_a; gl = ollr_a; gd = odat_a;
      ger = oerase_a; gc = ocnt_a; gt = otag_a; wl = {e.l1, e.l0};
    end
    nvec++;
    if (!(gv && gs == e.sop && ge == e.eop && gf == e.err && gl == wl && gd == wd &&
          ger == e.er && gc == e.cnt && gt == e.tag)) begin
      nerr++;
      $display("FAIL %s: got val=%b sop=%b eop=%b err=%b llr=%h dat=%b er=%b cnt=%0d tag=%h; want val=1 sop=%b eop=%b err=%b llr=%h dat=%b er=%b cnt=%0d tag=%h",
               nm, gv, gs, ge, gf, gl, gd, ger, gc, gt, e.sop, e.eop, e.err, wl, wd, e.er, e.cnt, e.tag);
    end
  endtask

  // One clock; checks the random-phase scoreboards after edges where that DUT was enabled.
  task automatic tick();
    logic ea, eb;
    ea = en_a; eb = en_b;
    @(negedge iclk);
    if (chk_a && ea) begin
      if (oval_a) begin
        if (expa.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL rand_a_extra_step: got cnt=%0d, want no step", ocnt_a);
        end else cmp_step("rand_a", 1'b0, expa.pop_front());
      end else if (oerr_a) begin
        nvec++; nerr++;
        $display("FAIL rand_a_err: got ofrm_err=1 without step, want 0");
      end
    end
    if (chk_b && eb) begin
      if (oval_b) begin
        if (expb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL rand_b_extra_step: got cnt=%0d, want no step", ocnt_b);
        end else cmp_step("rand_b", 1'b1, expb.pop_front());
      end else if (oerr_b) begin
        nvec++; nerr++;
        $display("FAIL rand_b_err: got ofrm_err=1 without step, want 0");
      end
    end
  endtask

  task automatic drive(input logic val, sop, eop, input logic [1:0] md, input logic [3:0] tg, lv, input bit rand_en);
    ival = val; isop = sop; ieop = eop; imode = md; itag = tg; illr = lv;
    if (rand_en) begin
      do begin
        en_b = 1'($urandom_range(0, 1));
        tick();
      end while (!en_b);
    end else tick();
  endtask

  task automatic chk_reset(input string nm);
    nvec++;
    if ({osop_a, oval_a, oeop_a, oerr_a, otag_a, ollr_a, odat_a, oerase_a, ocnt_a} != '0 ||
        {osop_b, oval_b, oeop_b, oerr_b, otag_b, ollr_b, odat_b, oerase_b, ocnt_b} != '0) begin
      nerr++;
      $display("FAIL %s: got a_val=%b a_llr=%h a_cnt=%0d b_val=%b b_cnt=%0d, want all outputs 0",
               nm, oval_a, ollr_a, ocnt_a, oval_b, ocnt_b);
    end
  endtask

  task automatic run_random(input bit b, input int frames);
    logic [3:0] sy [16];
    int m, n;
    logic [3:0] tg;
    for (int f = 0; f < frames; f++) begin
      m  = $urandom_range(0, 2);
      n  = $urandom_range(1, 9);
      tg = 4'($urandom);
      for (int i = 0; i < 16; i++) sy[i] = 4'($urandom);
      model(m, n, tg, sy, b);
      for (int i = 0; i < n; i++) begin
        drive(1'b1, i == 0, i == n - 1, 2'(m), tg, sy[i], b);
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'b0, 2'(m), tg, 4'($urandom), b);
      end
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 2'(m), tg, 4'h0, b);
    end
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    if (b) en_b = 1'b1;
    repeat (4) tick();
    nvec++;
    if ((b ? expb.size() : expa.size()) != 0) begin
      nerr++;
      $display("FAIL %s_drain: got %0d steps never emitted, want 0", b ? "rand_b" : "rand_a",
               b ? expb.size() : expa.size());
    end
  endtask

  initial begin
    vec_t  r;
    step_t e;
    ireset = 1'b0; en_a = 1'b1; en_b = 1'b0;
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; itag = 4'h0; imode = 2'd0; illr = 4'h0;

    // mode 0: +1,-2,+3,-4,+5,-6
    vn(1,1,0, 0, 5, 4'h1, 0);
    v (1,0,0, 0, 5, 4'hE, 1,1,0,0, 4'h1, 4'hE, 2'b00, 1);
    vn(1,0,0, 0, 5, 4'h3, 0);
    v (1,0,0, 0, 5, 4'hC, 1,0,0,0, 4'h3, 4'hC, 2'b00, 2);
    vn(1,0,0, 0, 5, 4'h5, 0);
    v (1,0,1, 0, 5, 4'hA, 1,0,1,0, 4'h5, 4'hA, 2'b00, 3);
    vn(0,0,0, 0, 5, 4'h0, 0);
    // mode 1: a..f
    vn(1,1,0, 1, 6, 4'h1, 0);
    v (1,0,0, 1, 6, 4'h2, 1,1,0,0, 4'h1, 4'h2, 2'b00, 1);
    v (1,0,0, 1, 6, 4'h3, 1,0,0,0, 4'h3, 4'h0, 2'b10, 2);
    vn(1,0,0, 1, 6, 4'h4, 0);
    v (1,0,0, 1, 6, 4'h5, 1,0,0,0, 4'h4, 4'h5, 2'b00, 3);
    v (1,0,1, 1, 6, 4'h6, 1,0,1,0, 4'h6, 4'h0, 2'b10, 4);
    // mode 2: a..d back to back
    vn(1,1,0, 2, 7, 4'h7, 0);
    v (1,0,0, 2, 7, 4'h9, 1,1,0,0, 4'h7, 4'h9, 2'b00, 1);
    v (1,0,0, 2, 7, 4'h2, 1,0,0,0, 4'h2, 4'h0, 2'b10, 2);
    v (1,0,1, 2, 7, 4'h3, 1,0,1,0, 4'h0, 4'h3, 2'b01, 3);
    vn(0,0,0, 0, 7, 4'h0, 0);
    // mode 0: ieop on first symbol of a step
    vn(1,1,0, 0, 8, 4'h1, 0);
    v (1,0,0, 0, 8, 4'h2, 1,1,0,0, 4'h1, 4'h2, 2'b00, 1);
    v (1,0,1, 0, 8, 4'h5, 1,0,1,1, 4'h5, 4'h0, 2'b10, 2);
    // isop&ieop on one symbol with two kept slots
    v (1,1,1, 0, 9, 4'h3, 1,1,1,1, 4'h3, 4'h0, 2'b10, 1);
    // symbols outside a frame are dropped
    vn(1,0,0, 0, 9, 4'h9, 0);
    vn(1,0,1, 0, 9, 4'h9, 0);
    // isop mid-step: partial step discarded
    vn(1,1,0, 0, 1, 4'h1, 0);
    vn(1,1,0, 0, 2, 4'h4, 1);
    v (1,0,1, 0, 2, 4'h5, 1,1,1,0, 4'h4, 4'h5, 2'b00, 1);
    // out-of-range mode falls back to mode 0
    vn(1,1,0, 3, 3, 4'h6, 1);
    v (1,0,1, 3, 3, 4'h7, 1,1,1,0, 4'h6, 4'h7, 2'b00, 1);
    vn(0,0,0, 0, 3, 4'h0, 0);

    repeat (2) tick();
    chk_reset("reset_state");
    ireset = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      drive(r.val, r.sop, r.eop, r.md, r.tg, r.lv, 1'b0);
      if (r.xv) begin
        e.l0 = r.x0; e.l1 = r.x1; e.er = r.xer; e.sop = r.xs; e.eop = r.xe;
        e.err = r.xf; e.cnt = 16'(r.xc); e.tag = r.tg;
        cmp_step($sformatf("vec%0d", i), 1'b0, e);
      end else begin
        nvec++;
        if (oval_a || osop_a || oeop_a || oerr_a != r.xf) begin
          nerr++;
          $display("FAIL vec%0d: got val=%b sop=%b eop=%b err=%b, want val=0 sop=0 eop=0 err=%b",
                   i, oval_a, osop_a, oeop_a, oerr_a, r.xf);
        end
      end
    end

    // reset in the middle of a frame, then a clean frame
    drive(1'b1, 1'b1, 1'b0, 2'd0, 4'h4, 4'h1, 1'b0);
    ival = 1'b0; isop = 1'b0;
    ireset = 1'b0;
    tick();
    chk_reset("reset_mid_frame");
    ireset = 1'b1;
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 4'h4, 4'h2, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 4'h4, 4'h3, 1'b0);
    e.l0 = 4'h2; e.l1 = 4'h3; e.er = 2'b00; e.sop = 1'b1; e.eop = 1'b1;
    e.err = 1'b0; e.cnt = 16'd1; e.tag = 4'h4;
    cmp_step("after_reset_frame", 1'b0, e);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);

    chk_a = 1'b1;
    run_random(1'b0, 40);
    chk_a = 1'b0;
    en_a  = 1'b0;
    chk_b = 1'b1;
    run_random(1'b1, 40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
